// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart transmit arbiter.
package uart_pkg;

   localparam int unsigned N_DEFAULT = 4;

   typedef enum logic [1:0] {
      S_DRAIN,
      S_IDLE,
      S_BUSY,
      S_GAP
   } arb_state_t;

   // Cycles the uart needs for one frame: start + 8 data + stop bits plus its ack cycle.
   function automatic int unsigned frame_cycles(input int unsigned syshz, input int unsigned baud);
      return 10 * (syshz / baud) + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request strictly after ptr, wrapping modulo N.
module rr_pick
   import uart_pkg::*;
#(
   parameter int unsigned N  = N_DEFAULT,
   parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          valid,
   output logic [PW-1:0] idx,
   output logic [N-1:0]  onehot
);

   logic [PW-1:0] cand;

   // Walk candidates from farthest (ptr+N) to nearest (ptr+1); the nearest hit is written last and wins.
   always_comb begin
      valid  = 1'b0;
      idx    = '0;
      onehot = '0;
      cand   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = PW'((32'(ptr) + N - k) % N);
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
      if (valid) begin
         onehot[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart transmitter among N byte producers.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_DRAIN | post-reset hold-off; waits out a frame the uart may still send
// S_IDLE  | no owner; pick the next requester round-robin
// S_BUSY  | frame owned by grant; waiting for uart_txack
// S_GAP   | one cycle; ack pulse visible, uart sees txreq low
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned N     = N_DEFAULT,
   parameter int unsigned SYSHZ = 100_000_000,
   parameter int unsigned BAUD  = 9600,
   parameter int unsigned DRAIN = 11 * (SYSHZ / BAUD)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [8*N-1:0] data,
   output logic [N-1:0]   ack,
   output logic [N-1:0]   grant,
   output logic           busy,
   output logic           uart_txreq,
   output logic [7:0]     uart_txdata,
   input  logic           uart_txack
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
   localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN - 1);
   localparam logic [PW-1:0] PTR_INIT   = PW'(N - 1);

   arb_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [N-1:0]  grant_d, ack_d;
   logic          txreq_d, busy_d;
   logic [7:0]    txdata_d;

   logic          pick_valid;
   logic [PW-1:0] pick_idx;
   logic [N-1:0]  pick_onehot;

   rr_pick #(
      .N  (N),
      .PW (PW)
   ) u_rr_pick (
      .req    (req),
      .ptr    (ptr_q),
      .valid  (pick_valid),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   // State and every output are registered; reset forces DRAIN because the uart is not reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_DRAIN;
         cnt_q       <= DRAIN_LAST;
         ptr_q       <= PTR_INIT;
         grant       <= '0;
         ack         <= '0;
         uart_txreq  <= 1'b0;
         uart_txdata <= 8'h00;
         busy        <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         grant       <= grant_d;
         ack         <= ack_d;
         uart_txreq  <= txreq_d;
         uart_txdata <= txdata_d;
         busy        <= busy_d;
      end
   end

   // Next-state and next-output logic; outputs hold unless a transition changes them.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      grant_d  = grant;
      ack_d    = '0;
      txreq_d  = uart_txreq;
      txdata_d = uart_txdata;

      unique case (state_q)
         S_DRAIN: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_IDLE: begin
            if (pick_valid) begin
               state_d  = S_BUSY;
               grant_d  = pick_onehot;
               txdata_d = data[{pick_idx, 3'b000} +: 8];
               txreq_d  = 1'b1;
               ptr_d    = pick_idx;
            end
         end
         S_BUSY: begin
            // req changes are deliberately ignored: once granted, the frame runs to txack.
            if (uart_txack) begin
               state_d = S_GAP;
               txreq_d = 1'b0;
               grant_d = '0;
               ack_d   = grant;
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_DRAIN;
            cnt_d   = DRAIN_LAST;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart transmit channel between N byte-producing requesters; arbitration is round-robin.
- Sits between the requesters and the uart instance: drives uart txreq/txdata, consumes uart txack.
- Owns a whole frame from grant to txack and routes the completion ack back to the granted requester.
- After reset, waits out any frame still in flight in the (reset-less) uart before issuing a new grant.

Parameters:
- N, 4, number of requesters (2..16).
- SYSHZ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, uart baud rate.
- DRAIN, 11*(SYSHZ/BAUD), post-reset hold-off in cycles; covers one full uart frame plus margin.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req  in  N  per-requester byte request; held high until that requester's ack pulse.
- data  in  8*N  byte for requester i at data[8*i+7:8*i]; stable while req[i] is high.
- ack  out  N  one-cycle pulse on bit i when requester i's byte has been fully shifted out.
- grant  out  N  one-hot; identifies the current owner of the uart; zero when no owner.
- busy  out  1  high in every state except IDLE.
- uart_txreq  out  1  connects to uart txreq.
- uart_txdata  out  8  connects to uart txdata; registered.
- uart_txack  in  1  connects to uart txack.

Behaviour:
- All outputs are registered.
- Reset values: ack=0, grant=0, uart_txreq=0, uart_txdata=8'h00, busy=1, state=DRAIN, drain counter=DRAIN-1, rr pointer=N-1.
- Reset is honoured in any state, including mid-frame. The uart keeps running regardless, which is why reset enters DRAIN.
- DRAIN:
  - Decrement the counter each cycle and ignore uart_txack.
  - When the counter reaches 0, go to IDLE on the next cycle.
- IDLE:
  - If req==0, stay.
  - Otherwise choose the first set bit searching from ptr+1 upward, wrapping modulo N.
  - Next cycle: grant=onehot(g), uart_txdata=data[g], uart_txreq=1, ptr=g, state=BUSY.
  - Arbitration latency from req to uart_txreq is 1 cycle.
- BUSY:
  - Hold uart_txreq, uart_txdata and grant stable.
  - Changes on req (including req[g] dropping, which is a protocol violation) do not abort the frame.
  - On uart_txack: next cycle uart_txreq=0, grant=0, ack[g]=1, state=GAP.
- GAP:
  - Exactly 1 cycle; ack pulse visible here; go to IDLE.
  - GAP guarantees IDLE samples req only after the acked requester has reacted to ack.
  - GAP also guarantees the uart sees txreq low when it returns idle.
- uart_txack outside BUSY is ignored (no ack, no state change).
- A requester holding req after its ack gets its next byte only via round-robin. With all requesters active, grants cycle 0,1,...,N-1,0.
- Arbitration to arbitration, per byte: 1 (IDLE) + uart frame + 1 (GAP).
- Simultaneous rst and uart_txack: rst wins.

Decomposition:
- Shared package uart_pkg holds:
  - state enum {DRAIN, IDLE, BUSY, GAP};
  - helper function for frame length 10*(SYSHZ/BAUD)+1;
  - default N.
- One natural sub-module, rr_pick: combinational round-robin search.
  - Inputs: req[N], ptr.
  - Outputs: valid, idx, onehot.
  - Reusable by other arbiters.

Test Plan:
- Bench settings: SYSHZ=100, BAUD=10 (frame = 10 cycles per bit), DRAIN=110, N=4, real uart instance.
- Reset then req=4'b0001, data0=8'hA5 at cycle 0: no uart_txreq before cycle 110. Then uart_txreq 1 cycle after IDLE entry, tx line shows 0,1,0,1,0,0,1,0,1,1 at 10-cycle steps, ack[0] pulses once, grant returns to 0.
- req=4'b1111 held, data i = 8'h10+i, re-asserted after each ack: grant order 0,1,2,3,0, and uart_txdata matches 8'h10..8'h13 in that order.
- Only requester 2 active, holding req across its ack: back-to-back bytes, each separated by exactly one GAP cycle and one IDLE cycle; no lost or duplicated ack.
- rst pulsed mid-frame while BUSY: outputs take reset values the next cycle. The uart's late txack arrives during DRAIN and produces no ack. The first post-DRAIN grant goes to the lowest set req bit (ptr=N-1 wrap).
- Spurious uart_txack forced in IDLE: no ack, no grant, state stays IDLE.
